// File: rtl/fetch_unit.sv
// Instruction-fetch front end: word reads from the system bus into a prefetch
// queue that feeds decode. Supports redirect with flush, and halts on bus error.
//
// state | meaning
// IDLE  | no transaction in flight; issue when the queue has room and the bus is idle
// WAIT  | request in flight; its response will be pushed into the queue
// DRAIN | request in flight made stale by a redirect; its response is dropped
// HALT  | last fetch errored; nothing issued until a redirect arrives
module fetch_unit #(
   parameter int unsigned       XLEN       = 32,
   parameter int unsigned       DEPTH      = 4,
   parameter logic [XLEN-1:0]   RESET_PC   = '0,
   parameter logic [1:0]        RESP_ERROR = 2'b11
) (
   input  logic            clock,
   input  logic            reset,
   output logic [XLEN-1:0] bus_address,
   output logic            bus_write,
   output logic            bus_start,
   input  logic            bus_ready,
   input  logic [1:0]      bus_response,
   input  logic [XLEN-1:0] bus_read_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_error,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            bus_start_q;
   logic [XLEN-1:0] bus_address_q;
   logic [XLEN-1:0] redirect_word;

   logic [XLEN-1:0] q_data_q [DEPTH];
   logic [XLEN-1:0] q_pc_q   [DEPTH];
   logic [DEPTH-1:0] q_err_q;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]   count_q;

   logic [XLEN-1:0] last_data_q, last_pc_q;
   logic            last_err_q;

   logic complete, issue, push, push_err, flush, pop;

   assign redirect_word = redirect_pc & ~XLEN'(3);

   // The request is still being presented while bus_start_q is high, so
   // bus_ready in that cycle belongs to the idle slave, not to a result.
   assign complete = ((state_q == S_WAIT) || (state_q == S_DRAIN)) &&
                     !bus_start_q && bus_ready;

   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid && inst_ready && !flush;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      issue      = 1'b0;
      push       = 1'b0;
      push_err   = 1'b0;
      flush      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_word;
            end else if ((count_q < CW'(DEPTH)) && bus_ready) begin
               issue   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_word;
               // A redirect on the completion edge leaves nothing in flight.
               state_d    = complete ? S_IDLE : S_DRAIN;
            end else if (complete) begin
               push = 1'b1;
               if (bus_response == RESP_ERROR) begin
                  push_err = 1'b1;
                  state_d  = S_HALT;
               end else if ((count_q + CW'(1)) < CW'(DEPTH)) begin
                  issue = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (redirect_valid) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_word;
            end
            if (complete) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            if (redirect_valid) begin
               flush      = 1'b1;
               fetch_pc_d = redirect_word;
               state_d    = S_IDLE;
            end
         end
      endcase
      if (issue) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= RESET_PC;
         bus_start_q   <= 1'b0;
         bus_address_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         bus_start_q <= issue;
         if (issue) begin
            bus_address_q <= fetch_pc_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // bus_address_q still holds the in-flight request address at completion.
   always_ff @(posedge clock) begin
      if (push) begin
         q_data_q[wr_ptr_q] <= bus_read_data;
         q_pc_q[wr_ptr_q]   <= bus_address_q;
         q_err_q[wr_ptr_q]  <= push_err;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_data_q <= '0;
         last_pc_q   <= '0;
         last_err_q  <= 1'b0;
      end else if (inst_valid) begin
         last_data_q <= q_data_q[rd_ptr_q];
         last_pc_q   <= q_pc_q[rd_ptr_q];
         last_err_q  <= q_err_q[rd_ptr_q];
      end
   end

   assign inst_data   = inst_valid ? q_data_q[rd_ptr_q] : last_data_q;
   assign inst_pc     = inst_valid ? q_pc_q[rd_ptr_q]   : last_pc_q;
   assign inst_error  = inst_valid ? q_err_q[rd_ptr_q]  : last_err_q;

   assign bus_address = bus_address_q;
   assign bus_start   = bus_start_q;
   assign bus_write   = 1'b0;
   assign busy        = (state_q == S_WAIT) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bus slave model, instruction-stream model checked every
// cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h100;
   localparam logic [1:0]  RESP_ERROR = 2'b11;

   logic        clock, reset;
   logic [31:0] bus_address;
   logic        bus_write, bus_start, bus_ready;
   logic [1:0]  bus_response;
   logic [31:0] bus_read_data;
   logic        inst_valid, inst_ready, inst_error;
   logic [31:0] inst_data, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;

   fetch_unit #(
      .XLEN(32), .DEPTH(4), .RESET_PC(RESET_PC), .RESP_ERROR(RESP_ERROR)
   ) dut (
      .clock(clock), .reset(reset),
      .bus_address(bus_address), .bus_write(bus_write), .bus_start(bus_start),
      .bus_ready(bus_ready), .bus_response(bus_response), .bus_read_data(bus_read_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_error(inst_error),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Slave: drops ready on the sampling edge, returns 0xA0+addr after s_wait cycles.
   logic        s_ready, s_pending, s_stale, s_halt;
   logic [31:0] s_addr, s_rdata;
   logic [1:0]  s_resp;
   int          s_cnt, s_compl;
   int          s_wait;
   logic        err_en;
   logic [31:0] err_addr;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_ready <= 1'b1; s_pending <= 1'b0; s_stale <= 1'b0; s_halt <= 1'b0;
         s_addr <= '0; s_rdata <= '0; s_resp <= 2'b00; s_cnt <= 0; s_compl <= 0;
      end else begin
         if (s_pending && s_ready) begin
            s_pending <= 1'b0;
            s_compl   <= s_compl + 1;
            if (s_resp == RESP_ERROR && !s_stale && !redirect_valid) s_halt <= 1'b1;
         end else if (bus_start && s_ready) begin
            s_ready   <= 1'b0;
            s_pending <= 1'b1;
            s_addr    <= bus_address;
            s_cnt     <= s_wait;
            s_stale   <= 1'b0;
         end else if (s_pending) begin
            if (s_cnt == 0) begin
               s_ready <= 1'b1;
               s_rdata <= 32'hA0 + s_addr;
               s_resp  <= (err_en && s_addr == err_addr) ? RESP_ERROR : 2'b00;
            end else begin
               s_cnt <= s_cnt - 1;
            end
         end
         if (redirect_valid) begin
            s_halt <= 1'b0;
            if (s_pending || bus_start) s_stale <= 1'b1;
         end
      end
   end

   assign bus_ready     = s_ready;
   assign bus_response  = s_resp;
   assign bus_read_data = s_rdata;

   int          n_tests, n_fail;
   logic [31:0] exp_pc, exp_fetch, last_pc, last_data;
   logic        last_err, err_seen;
   logic [31:0] issue_log[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_data[$];
   logic        pop_err[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
      end
   endtask

   // Stream model: instructions appear in pc order, +4 each, restarting at each redirect.
   task automatic model_check();
      if (!reset) begin
         exp_pc = RESET_PC; exp_fetch = RESET_PC;
         last_pc = '0; last_data = '0; last_err = 1'b0; err_seen = 1'b0;
         issue_log.delete(); pop_pc.delete(); pop_data.delete(); pop_err.delete();
      end else begin
         chk1("bus_write", bus_write, 1'b0);
         chk1("busy", busy, bus_start || s_pending);
         chk1("issue_after_error", bus_start && s_halt, 1'b0);
         if (bus_start) begin
            chk1("start_when_ready", s_ready, 1'b1);
            chk("fetch_addr", bus_address, exp_fetch);
            issue_log.push_back(bus_address);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (inst_valid) begin
            chk1("valid_after_error", err_seen, 1'b0);
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, 32'hA0 + exp_pc);
            chk1("inst_error", inst_error, err_en && (exp_pc == err_addr));
            last_pc = inst_pc; last_data = inst_data; last_err = inst_error;
            if (inst_ready && !redirect_valid) begin
               pop_pc.push_back(inst_pc);
               pop_data.push_back(inst_data);
               pop_err.push_back(inst_error);
               if (inst_error) err_seen = 1'b1;
               exp_pc = exp_pc + 32'd4;
            end
         end else begin
            chk("hold_pc", inst_pc, last_pc);
            chk("hold_data", inst_data, last_data);
            chk1("hold_error", inst_error, last_err);
         end
         if (redirect_valid) begin
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            err_seen  = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      model_check();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_bus_start"}, bus_start, 1'b0);
      chk({tag, "_bus_address"}, bus_address, 32'h0);
      chk1({tag, "_bus_write"}, bus_write, 1'b0);
      chk1({tag, "_inst_valid"}, inst_valid, 1'b0);
      chk({tag, "_inst_data"}, inst_data, 32'h0);
      chk({tag, "_inst_pc"}, inst_pc, 32'h0);
      chk1({tag, "_inst_error"}, inst_error, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic wait_pops(input int n, input int budget);
      int b = budget;
      while (pop_pc.size() < n && b > 0) begin tick(); b--; end
      chk("timeout_pops", 32'(pop_pc.size() >= n), 32'd1);
   endtask

   task automatic wait_issues(input int n, input int budget);
      int b = budget;
      while (issue_log.size() < n && b > 0) begin tick(); b--; end
      chk("timeout_issues", 32'(issue_log.size() >= n), 32'd1);
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      int n;
      n_tests = 0; n_fail = 0;
      reset = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      s_wait = 1; err_en = 1'b0; err_addr = '0;

      // Sequential fetch with a one-wait slave
      do_reset();
      reset = 1'b0;
      #1 check_reset_outputs("t1_reset");
      reset = 1'b1;
      inst_ready = 1'b1;
      wait_pops(3, 200);
      chk("t1_addr0", issue_log[0], 32'h100);
      chk("t1_addr1", issue_log[1], 32'h104);
      chk("t1_addr2", issue_log[2], 32'h108);
      chk("t1_data0", pop_data[0], 32'h1A0);
      chk("t1_data1", pop_data[1], 32'h1A4);
      chk("t1_data2", pop_data[2], 32'h1A8);
      chk("t1_pc2", pop_pc[2], 32'h108);

      // Backpressure: queue fills to DEPTH, then fetching resumes after pops
      inst_ready = 1'b0;
      do_reset();
      repeat (80) tick();
      chk("t2_issue_count", 32'(issue_log.size()), 32'd4);
      inst_ready = 1'b1;
      wait_pops(4, 100);
      chk("t2_pop0", pop_pc[0], 32'h100);
      chk("t2_pop3", pop_pc[3], 32'h10C);
      wait_issues(5, 100);
      chk("t2_resume", issue_log[4], 32'h110);

      // Redirect while 0x104 is in flight
      s_wait = 3;
      do_reset();
      wait_issues(2, 200);
      chk("t3_inflight", issue_log[1], 32'h104);
      redirect_to(32'h203);
      n = pop_pc.size();
      wait_pops(n + 1, 200);
      chk("t3_first_pc", pop_pc[n], 32'h200);
      chk("t3_first_issue", issue_log[2], 32'h200);

      // Error response halts fetching until a redirect
      s_wait = 1; err_en = 1'b1; err_addr = 32'h108;
      do_reset();
      wait_pops(3, 200);
      chk("t4_err_pc", pop_pc[2], 32'h108);
      chk1("t4_err_flag", pop_err[2], 1'b1);
      repeat (30) tick();
      chk("t4_no_issue", 32'(issue_log.size()), 32'd3);
      redirect_to(32'h40);
      wait_pops(4, 200);
      chk("t4_resume_pc", pop_pc[3], 32'h40);
      chk1("t4_resume_err", pop_err[3], 1'b0);
      chk("t4_resume_issue", issue_log[3], 32'h40);
      err_en = 1'b0;

      // Redirect and pop on the same edge with three entries queued
      inst_ready = 1'b0; s_wait = 3;
      do_reset();
      begin
         int b = 300;
         while (s_compl < 3 && b > 0) begin tick(); b--; end
      end
      chk("t5_queued", 32'(s_compl), 32'd3);
      chk1("t5_valid_before", inst_valid, 1'b1);
      inst_ready = 1'b1;
      redirect_to(32'h300);
      @(negedge clock);
      chk1("t5_empty_after", inst_valid, 1'b0);
      @(posedge clock); #1;
      wait_pops(3, 300);
      chk("t5_new0", pop_pc[0], 32'h300);
      chk("t5_new1", pop_pc[1], 32'h304);
      chk("t5_new2", pop_pc[2], 32'h308);

      // Asynchronous reset in the middle of a transaction
      do_reset();
      begin
         int b = 200;
         while (!(busy && !bus_start) && b > 0) begin tick(); b--; end
      end
      chk1("t6_in_wait", busy, 1'b1);
      #2 reset = 1'b0;
      #1 check_reset_outputs("t6_reset");
      tick();
      tick();
      reset = 1'b1;
      wait_issues(1, 100);
      chk("t6_first_issue", issue_log[0], RESET_PC);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
